// File: rtl/issue_unit.sv
// Round-robin issue arbiter for the INT/MUL/DIV/LS issue queues with CDB slot reservation
// and divider occupancy tracking. Define ISSUE_STATS_EN to enable the saturating per-queue grant counters.
module issue_unit #(
    parameter int INT_LAT = 1,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 6,
    parameter int LS_LAT  = 2,
    parameter int RES_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        int_ready,
    input  logic        mul_ready,
    input  logic        div_ready,
    input  logic        ls_ready,
    output logic        int_issue,
    output logic        mul_issue,
    output logic        div_issue,
    output logic        ls_issue,
    output logic        issue_valid,
    output logic [1:0]  issue_sel,
    output logic        cdb_expect,
    output logic        div_busy,
    output logic [15:0] stat_int_cnt,
    output logic [15:0] stat_mul_cnt,
    output logic [15:0] stat_div_cnt,
    output logic [15:0] stat_ls_cnt
);

    localparam int DCW = $clog2(DIV_LAT + 1);

    logic [RES_W-1:0] res_reg, res_next;
    logic [DCW-1:0]   div_cnt_reg, div_cnt_next;
    logic [1:0]       rr_ptr_reg, rr_ptr_next;
    logic [3:0]       ready_vec, elig_vec, grant_vec;
    logic [RES_W-1:0] set_mask [4];
    logic [1:0]       sel;
    logic             div_free;

    assign ready_vec = {ls_ready, div_ready, mul_ready, int_ready};
    assign div_free  = (div_cnt_reg == '0);

    // Per-queue eligibility and the reservation bit a grant books (slot LAT lands in LAT-1 after the shift).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_queue
            localparam int LAT = (gi == 0) ? INT_LAT :
                                 (gi == 1) ? MUL_LAT :
                                 (gi == 2) ? DIV_LAT : LS_LAT;
            localparam bit IS_DIV = (gi == 2);
            assign elig_vec[gi] = rst_n & ready_vec[gi] & ~res_reg[LAT] & (div_free | ~IS_DIV);
            assign set_mask[gi] = grant_vec[gi] ? (RES_W'(1) << (LAT - 1)) : '0;
        end
    endgenerate

    always_comb begin : arb
        logic [1:0] idx;
        logic       found;
        grant_vec = '0;
        sel       = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr_reg + 2'(k);
            if (!found && elig_vec[idx]) begin
                found          = 1'b1;
                grant_vec[idx] = 1'b1;
                sel            = idx;
            end
        end
    end

    assign {ls_issue, div_issue, mul_issue, int_issue} = grant_vec;
    assign issue_valid = |grant_vec;
    assign issue_sel   = sel;
    assign cdb_expect  = res_reg[0];
    assign div_busy    = ~div_free;

    always_comb begin
        res_next     = (res_reg >> 1) | set_mask[0] | set_mask[1] | set_mask[2] | set_mask[3];
        rr_ptr_next  = issue_valid ? sel + 2'd1 : rr_ptr_reg;
        div_cnt_next = div_cnt_reg;
        if (grant_vec[2]) begin
            div_cnt_next = DCW'(DIV_LAT - 1);
        end else if (!div_free) begin
            div_cnt_next = div_cnt_reg - DCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_reg     <= '0;
            div_cnt_reg <= '0;
            rr_ptr_reg  <= '0;
        end else begin
            res_reg     <= res_next;
            div_cnt_reg <= div_cnt_next;
            rr_ptr_reg  <= rr_ptr_next;
        end
    end

`ifdef ISSUE_STATS_EN
    logic [15:0] stat_reg [4];

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst_n) begin
                stat_reg[k] <= '0;
            end else if (grant_vec[k] && stat_reg[k] != 16'hFFFF) begin
                stat_reg[k] <= stat_reg[k] + 16'd1;
            end
        end
    end

    assign stat_int_cnt = stat_reg[0];
    assign stat_mul_cnt = stat_reg[1];
    assign stat_div_cnt = stat_reg[2];
    assign stat_ls_cnt  = stat_reg[3];
`else
    assign stat_int_cnt = '0;
    assign stat_mul_cnt = '0;
    assign stat_div_cnt = '0;
    assign stat_ls_cnt  = '0;
`endif

endmodule
